// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MEM/WB pipeline types, widths and occupancy encoding
package mips_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEST_W = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    // Field order matches the concatenation used to pack the payload in the top.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] PC;
        logic [DEF_DATA_W-1:0] ALU_result;
        logic [DEF_DATA_W-1:0] Mem_Data;
        logic [DEF_DEST_W-1:0] dest;
        logic                  WB_En;
        logic                  MEM_R_En;
    } mem_wb_payload_t;

    localparam mem_wb_payload_t MEM_WB_PAYLOAD_RST = '0;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - width-generic payload register with load enable and synchronous clear
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// rtl/mem_wb_elastic_reg.sv - elastic MEM/WB register with 2-entry skid buffer, flush and stall counter
module mem_wb_elastic_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEST_W = DEF_DEST_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] Mem_Data_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic              WB_En_in,
    input  logic              MEM_R_En_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] Mem_Data,
    output logic [DEST_W-1:0] dest,
    output logic              WB_En,
    output logic              MEM_R_En,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PAY_W = 3 * DATA_W + DEST_W + 2;

    pipe_state_t      state_q, state_d;
    logic             main_v, skid_v;
    logic             accept, pop;
    logic             main_ld, skid_ld, main_sel_skid;
    logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;
    logic             wb_en_raw, mem_r_en_raw;
    logic [CNT_W-1:0] stall_q;

    assign main_v    = (state_q != ST_EMPTY);
    assign skid_v    = (state_q == ST_TWO);
    // Decoded purely from the state flop, so out_ready never reaches in_ready.
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign in_pay = {PC_in, ALU_result_in, Mem_Data_in, dest_in, WB_En_in, MEM_R_En_in};
    assign main_d = main_sel_skid ? skid_q : in_pay;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_ld       = 1'b0;
        skid_ld       = 1'b0;
        main_sel_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_ld = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d       = ST_ONE;
                        main_ld       = 1'b1;
                        main_sel_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    pipe_payload_reg #(.W(PAY_W)) u_main (
        .clk  (clk),
        .clr  (rst),
        .load (main_ld),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_payload_reg #(.W(PAY_W)) u_skid (
        .clk  (clk),
        .clr  (rst),
        .load (skid_ld),
        .d    (in_pay),
        .q    (skid_q)
    );

    assign {PC, ALU_result, Mem_Data, dest, wb_en_raw, mem_r_en_raw} = main_q;
    // Stale controls left behind by a flush or pop must not look like a write.
    assign WB_En    = wb_en_raw && main_v;
    assign MEM_R_En = mem_r_en_raw && main_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// tb/tb_mem_wb_elastic_reg.sv - directed self-checking bench for mem_wb_elastic_reg
module tb_mem_wb_elastic_reg;

    localparam int DATA_W = 32;
    localparam int DEST_W = 5;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] PC_in, ALU_result_in, Mem_Data_in;
    logic [DATA_W-1:0] PC, ALU_result, Mem_Data;
    logic [DEST_W-1:0] dest_in, dest;
    logic              WB_En_in, MEM_R_En_in, WB_En, MEM_R_En;
    logic [CNT_W-1:0]  stall_cnt;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    mem_wb_elastic_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .PC_in         (PC_in),
        .ALU_result_in (ALU_result_in),
        .Mem_Data_in   (Mem_Data_in),
        .dest_in       (dest_in),
        .WB_En_in      (WB_En_in),
        .MEM_R_En_in   (MEM_R_En_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .PC            (PC),
        .ALU_result    (ALU_result),
        .Mem_Data      (Mem_Data),
        .dest          (dest),
        .WB_En         (WB_En),
        .MEM_R_En      (MEM_R_En),
        .stall_cnt     (stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        PC_in = '0; ALU_result_in = '0; Mem_Data_in = '0; dest_in = '0;
        WB_En_in = 1'b0; MEM_R_En_in = 1'b0;

        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_pc", PC, 0);
        check("rst_alu", ALU_result, 0);
        check("rst_wb_en", WB_En, 0);
        check("rst_stall", stall_cnt, 0);
        in_valid = 1'b1; ALU_result_in = 32'h55; out_ready = 1'b1;
        tick();
        check("rst_blocks_accept", out_valid, 0);
        check("rst_alu_2", ALU_result, 0);

        rst = 1'b0; WB_En_in = 1'b1; MEM_R_En_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ALU_result_in = 32'h10 + i;
            Mem_Data_in   = 32'hA0 + i;
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_alu", ALU_result, 32'h10 + i);
            check("stream_in_ready", in_ready, 1);
        end
        check("stream_mem_data", Mem_Data, 32'hA2);
        check("stream_mem_r_en", MEM_R_En, 1);
        check("stream_stall", stall_cnt, 0);
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_wb_gated", WB_En, 0);
        check("drain_memr_gated", MEM_R_En, 0);

        out_ready = 1'b0; in_valid = 1'b1; PC_in = 32'h100;
        tick();
        check("bp_first_pc", PC, 32'h100);
        check("bp_first_ready", in_ready, 1);
        check("bp_first_stall", stall_cnt, 0);
        PC_in = 32'h104;
        tick();
        check("bp_two_ready", in_ready, 0);
        check("bp_two_pc", PC, 32'h100);
        check("bp_two_stall", stall_cnt, 1);
        PC_in = 32'h108;
        tick();
        check("bp_hold_pc", PC, 32'h100);
        check("bp_hold_stall", stall_cnt, 2);
        check("bp_hold_ready", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_rel_pc", PC, 32'h104);
        check("bp_rel_valid", out_valid, 1);
        check("bp_rel_ready", in_ready, 1);
        check("bp_rel_stall", stall_cnt, 2);
        tick();
        check("bp_empty", out_valid, 0);

        in_valid = 1'b1; dest_in = 5'd3; out_ready = 1'b0;
        tick();
        check("pp_dest3", dest, 3);
        dest_in = 5'd7; out_ready = 1'b1;
        tick();
        check("pp_dest7", dest, 7);
        check("pp_valid", out_valid, 1);
        check("pp_skid_empty", in_ready, 1);

        in_valid = 1'b1; out_ready = 1'b0; PC_in = 32'h1F0;
        tick();
        check("fl_two", in_ready, 0);
        flush = 1'b1; PC_in = 32'h200; WB_En_in = 1'b1;
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_wb_en", WB_En, 0);
        check("fl_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fl_no_resurrect", out_valid, 0);
        check("fl_stall_kept", (stall_cnt != 0), 1);

        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b1; PC_in = 32'h300; out_ready = 1'b0;
        tick();
        check("sat_start", stall_cnt, 0);
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7) check("sat_reach7", stall_cnt, 7);
        end
        check("sat_hold7", stall_cnt, 7);
        check("sat_pc_held", PC, 32'h300);

        in_valid = 1'b1; PC_in = 32'h304;
        tick();
        check("ms_two", in_ready, 0);
        rst = 1'b1;
        tick();
        check("ms_valid", out_valid, 0);
        check("ms_stall", stall_cnt, 0);
        check("ms_ready", in_ready, 1);
        check("ms_pc", PC, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("ms_discarded", out_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_wb_elastic_reg.md
Name: mem_wb_elastic_reg

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register in the MIPS core.
- Carries PC, ALU result, memory data, destination register and WB/MEM-read controls from the MEM stage to the WB stage.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops data.
- Adds a synchronous flush that kills in-flight entries, and a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 32, width of PC, ALU result and memory data fields.
- DEST_W, 5, width of the destination register index.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill all held entries; takes effect at this clock edge.
- in_valid  in  1  MEM stage presents a valid entry.
- in_ready  out  1  block can accept an entry this cycle.
- PC_in  in  DATA_W  program counter of the incoming entry.
- ALU_result_in  in  DATA_W  ALU result.
- Mem_Data_in  in  DATA_W  data read from memory.
- dest_in  in  DEST_W  destination register index.
- WB_En_in  in  1  write-back enable.
- MEM_R_En_in  in  1  memory-read enable (selects Mem_Data at WB).
- out_valid  out  1  head entry valid.
- out_ready  in  1  WB stage consumes the head entry this cycle.
- PC, ALU_result, Mem_Data  out  DATA_W  head entry fields.
- dest  out  DEST_W  head entry destination.
- WB_En, MEM_R_En  out  1  head entry controls, gated: 0 whenever out_valid=0.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage:
  - main register (drives the outputs).
  - skid register (absorbs one entry during back-pressure).
  - State EMPTY / ONE / TWO, held as main_v / skid_v.
- Handshakes:
  - in_ready = !skid_v, driven from a flop (no combinational path from out_ready).
  - Accept occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
- Transitions (evaluated at posedge, flush/rst absent):
  - EMPTY, accept -> ONE; main <= input.
  - ONE:
    - accept and pop -> ONE; main <= input.
    - accept only -> TWO; skid <= input.
    - pop only -> EMPTY.
    - neither -> ONE; hold.
  - TWO:
    - pop -> ONE; main <= skid. No accept is possible, since in_ready=0.
    - no pop -> TWO; hold.
- Latency and ordering:
  - Latency is 1 cycle input -> output when not stalled.
  - Entries leave in arrival order.
  - No entry is lost or duplicated.
- Flush:
  - Next state is EMPTY, and any accept in the same cycle is discarded.
  - out_valid=0 and in_ready=1 from the next cycle.
  - Data fields are don't-care after flush.
  - stall_cnt is not affected.
- Reset:
  - All data outputs 0, out_valid=0, WB_En=0, MEM_R_En=0, in_ready=1, stall_cnt=0.
  - rst has priority over flush and over every handshake.
  - rst asserted mid-stall discards both entries.
- stall_cnt:
  - Increments by 1 each cycle out_valid && !out_ready.
  - Saturates at 2^CNT_W-1, never wraps.
  - Cleared only by rst.
- Widths: all fields pass through unmodified; no arithmetic other than the counter.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - state encoding (ST_EMPTY, ST_ONE, ST_TWO).
  - default field widths (DATA_W=32, DEST_W=5).
  - a packed MEM/WB payload type with field order {PC, ALU_result, Mem_Data, dest, WB_En, MEM_R_En}.
  - the payload reset constant (all zero).
- Sub-module pipe_payload_reg: width-generic register with load enable and synchronous clear, instantiated twice (main, skid).

Test Plan:
- Reset then streaming:
  - Stimulus: rst held 2 cycles, then in_valid=1 and out_ready=1 with ALU_result_in = 0x10, 0x11, 0x12 on consecutive cycles.
  - Response: all outputs 0 and in_ready=1 during reset; then outputs 0x10, 0x11, 0x12 each one cycle later; stall_cnt stays 0.
- Back-pressure:
  - Stimulus: out_ready=0 while pushing PC=0x100, then PC=0x104.
  - Response: in_ready drops to 0 after the second accept; PC holds 0x100; stall_cnt increments each stalled cycle.
  - Follow-up: release out_ready.
  - Response: 0x100 then 0x104 appear, and in_ready returns to 1.
- Simultaneous push/pop in ONE:
  - Stimulus: main holds dest=3; in_valid=1 with dest_in=7 and out_ready=1 in the same cycle.
  - Response: next cycle dest=7, out_valid=1, skid remains empty.
- Flush:
  - Stimulus: block in TWO; flush=1 with in_valid=1 and PC_in=0x200.
  - Response: next cycle out_valid=0, WB_En=0, in_ready=1; 0x200 never appears at the output.
- Counter saturation:
  - Stimulus: CNT_W=3, out_valid held with out_ready=0 for 10 cycles.
  - Response: stall_cnt reaches 7 and stays at 7.
- Reset mid-stall:
  - Stimulus: block in TWO; rst=1 for 1 cycle.
  - Response: out_valid=0, stall_cnt=0, in_ready=1.
